// File: rtl/decision_unit.sv
// Decision stage: scans a snapshot of the current bin for the lowest-index free
// variable, assigns it the default polarity and opens a new decision level.
module decision_unit #(
  parameter int NUM_VARS         = 8,
  parameter int WIDTH_LVL        = 10,
  parameter bit DEFAULT_POLARITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_decide_i,
  input  logic [NUM_VARS*3-1:0] var_value_i,
  output logic [NUM_VARS*3-1:0] var_value_o,
  output logic                  valid_from_decision_o,
  output logic [WIDTH_LVL-1:0]  cur_level_o,
  output logic [7:0]            decided_idx_o,
  output logic                  all_assigned_o,
  output logic                  lvl_overflow_o,
  input  logic                  apply_bkt_i,
  input  logic [WIDTH_LVL-1:0]  bkt_lvl_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_t;

  localparam logic [2:0]           DEC_CODE = DEFAULT_POLARITY ? 3'b010 : 3'b001;
  localparam logic [WIDTH_LVL-1:0] MAX_LVL  = '1;
  localparam logic [7:0]           LAST_IDX = 8'(NUM_VARS - 1);

  state_t                state_q, state_n;
  logic [7:0]            idx_q, idx_n;
  logic [NUM_VARS*3-1:0] snap_q, snap_n;
  logic [NUM_VARS*3-1:0] vars_q, vars_n;
  logic [WIDTH_LVL-1:0]  level_q, level_n;
  logic [7:0]            didx_q, didx_n;
  logic                  valid_q, valid_n;
  logic                  all_q, all_n;
  logic                  ovf_q, ovf_n;
  logic                  cur_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      vars_q  <= '0;
      level_q <= '0;
      didx_q  <= '0;
      valid_q <= 1'b0;
      all_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      snap_q  <= snap_n;
      vars_q  <= vars_n;
      level_q <= level_n;
      didx_q  <= didx_n;
      valid_q <= valid_n;
      all_q   <= all_n;
      ovf_q   <= ovf_n;
    end
  end

  // Outputs for DECIDE/DONE are computed in the last SCAN cycle and registered,
  // so they become visible in the very cycle the FSM sits in DECIDE or DONE.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    snap_n   = snap_q;
    vars_n   = vars_q;
    level_n  = level_q;
    didx_n   = didx_q;
    valid_n  = 1'b0;
    all_n    = 1'b0;
    ovf_n    = ovf_q;
    cur_free = (snap_q[int'(idx_q)*3 +: 2] == 2'b00);

    if (apply_bkt_i) begin
      state_n = IDLE;
      idx_n   = '0;
      level_n = bkt_lvl_i;
      ovf_n   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_decide_i) begin
            snap_n  = var_value_i;
            idx_n   = '0;
            state_n = SCAN;
          end
        end
        SCAN: begin
          if (cur_free) begin
            state_n = DECIDE;
            if (level_q == MAX_LVL) begin
              ovf_n = 1'b1;
            end else begin
              valid_n                       = 1'b1;
              level_n                       = level_q + 1'b1;
              didx_n                        = idx_q;
              vars_n                        = snap_q;
              vars_n[int'(idx_q)*3 +: 3]    = DEC_CODE;
            end
          end else if (idx_q == LAST_IDX) begin
            state_n = DONE;
            all_n   = 1'b1;
            vars_n  = snap_q;
          end else begin
            idx_n = idx_q + 8'd1;
          end
        end
        DECIDE:  state_n = IDLE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign var_value_o           = vars_q;
  assign valid_from_decision_o = valid_q;
  assign cur_level_o           = level_q;
  assign decided_idx_o         = didx_q;
  assign all_assigned_o        = all_q;
  assign lvl_overflow_o        = ovf_q;
  assign busy_o                = (state_q != IDLE);

endmodule
